memory_arbiter: RTL

//  Shares the single main-memory block port between the instruction cache (read-only) and
//  the data cache (read/write refill and write-back).

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_grant_sel.sv | 33 +++
 rtl/memory_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory arbiter: state encoding, width defaults and owner codes.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 28;
    localparam int unsigned DEF_BLOCK_WIDTH = 128;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_ACCESS = 2'd1;
    localparam logic [1:0] ARB_RESP   = 2'd2;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic [1:0] {
        StIdle   = ARB_IDLE,
        StAccess = ARB_ACCESS,
        StResp   = ARB_RESP
    } arb_state_e;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner select between I-cache and D-cache requests.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the cache not served last; otherwise D always wins ties.
module arb_grant_sel
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_owner,
    output logic winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = OWNER_I;
        if (i_req && d_req) begin
            winner = ~last_owner;
        end else if (d_req) begin
            winner = OWNER_D;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        winner = OWNER_I;
        if (d_req) begin
            winner = OWNER_D;
        end
    end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Shares the main-memory block port between I-cache and D-cache, one full transaction per grant.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking (default: fixed D-over-I).
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned BLOCK_WIDTH = DEF_BLOCK_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_mem_read,
    input  logic [ADDR_WIDTH-1:0]  i_mem_address,
    output logic [BLOCK_WIDTH-1:0] i_mem_readdata,
    output logic                   i_mem_busywait,
    input  logic                   d_mem_read,
    input  logic                   d_mem_write,
    input  logic [ADDR_WIDTH-1:0]  d_mem_address,
    input  logic [BLOCK_WIDTH-1:0] d_mem_writedata,
    output logic [BLOCK_WIDTH-1:0] d_mem_readdata,
    output logic                   d_mem_busywait,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [BLOCK_WIDTH-1:0] mem_writedata,
    input  logic [BLOCK_WIDTH-1:0] mem_readdata,
    input  logic                   mem_busywait,
    output logic                   grant_d
);

    arb_state_e             state_q;
    logic                   owner_q;
    logic                   mem_read_q;
    logic                   mem_write_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [BLOCK_WIDTH-1:0] wdata_q;
    logic [BLOCK_WIDTH-1:0] i_rdata_q;
    logic [BLOCK_WIDTH-1:0] d_rdata_q;

    logic i_req;
    logic d_req;
    logic winner;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

    // owner_q doubles as the last-served record for round-robin tie breaking
    arb_grant_sel u_grant_sel (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_owner (owner_q),
        .winner     (winner)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            owner_q     <= OWNER_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_req || d_req) begin
                        state_q <= StAccess;
                        owner_q <= winner;
                        if (winner == OWNER_D) begin
                            // read+write together is treated as a write-back
                            mem_write_q <= d_mem_write;
                            mem_read_q  <= ~d_mem_write;
                            addr_q      <= d_mem_address;
                            wdata_q     <= d_mem_writedata;
                        end else begin
                            mem_write_q <= 1'b0;
                            mem_read_q  <= 1'b1;
                            addr_q      <= i_mem_address;
                        end
                    end
                end
                StAccess: begin
                    if (!mem_busywait && (mem_read_q || mem_write_q)) begin
                        if (owner_q == OWNER_D) begin
                            d_rdata_q <= mem_readdata;
                        end else begin
                            i_rdata_q <= mem_readdata;
                        end
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = addr_q;
    assign mem_writedata  = wdata_q;
    assign grant_d        = owner_q;
    assign i_mem_readdata = i_rdata_q;
    assign d_mem_readdata = d_rdata_q;

    // A request stalls from the cycle it is raised until its owner's RESP cycle
    assign i_mem_busywait = i_req && !((state_q == StResp) && (owner_q == OWNER_I));
    assign d_mem_busywait = d_req && !((state_q == StResp) && (owner_q == OWNER_D));

endmodule
